// File: rtl/square_pkg.sv
// square_pkg: shared screen constants, coordinate type and drawer state encoding
package square_pkg;
  localparam int COORD_W  = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SQ_SIZE  = 20;
  typedef logic [COORD_W-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISHED} draw_state_t;
endpackage

// File: rtl/square_scan_counter.sv
// square_scan_counter: row-major cx/cy scan over a SIZE x SIZE square (clk, reset, clear, en -> cx, cy, last)
module square_scan_counter #(
  parameter int SIZE = 20,
  localparam int W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cx,
  output logic [W-1:0] cy,
  output logic         last
);
  localparam logic [W-1:0] MAX = W'(SIZE - 1);
  logic [W-1:0] cx_q, cx_d, cy_q, cy_d;
  always_comb begin
    cx_d = clear ? '0 : !en ? cx_q : (cx_q == MAX) ? '0 : cx_q + 1'b1;
    cy_d = clear ? '0 : (en && cx_q == MAX) ? cy_q + 1'b1 : cy_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end
  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == MAX) && (cy_q == MAX);
endmodule

// File: rtl/square_drawer.sv
// square_drawer: erases the previous square then draws a new SIZE x SIZE square, one clipped pixel per clock
module square_drawer
  import square_pkg::*;
#(
  parameter int SIZE = SQ_SIZE,
  parameter int SCR_W = SCREEN_W,
  parameter int SCR_H = SCREEN_H,
  localparam int W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  coord_t x_loc,
  input  coord_t y_loc,
  output coord_t pixel_x,
  output coord_t pixel_y,
  output logic   pixel_color,
  output logic   pixel_we,
  output logic   busy,
  output logic   done
);
  draw_state_t state_q, state_d;
  logic have_prev_q;
  coord_t new_x_q, new_y_q, prev_x_q, prev_y_q;
  logic [W-1:0] cx, cy;
  logic last, accept;
  logic [COORD_W:0] sx, sy;
  coord_t bx, by;
  assign busy   = (state_q == ERASE) || (state_q == DRAW);
  assign accept = (state_q == IDLE) && start;
  square_scan_counter #(.SIZE(SIZE)) u_scan (
    .clk  (clk),
    .reset(reset),
    .clear(!busy || last),
    .en   (busy),
    .cx   (cx),
    .cy   (cy),
    .last (last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start ? (have_prev_q ? ERASE : DRAW) : IDLE;
      ERASE:    state_d = last ? DRAW : ERASE;
      DRAW:     state_d = last ? FINISHED : DRAW;
      FINISHED: state_d = start ? FINISHED : IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      have_prev_q <= 1'b0;
      new_x_q     <= '0;
      new_y_q     <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        new_x_q <= x_loc;
        new_y_q <= y_loc;
      end
      if (state_q == DRAW && last) begin
        prev_x_q    <= new_x_q;
        prev_y_q    <= new_y_q;
        have_prev_q <= 1'b1;
      end
    end
  end
  // one extra adder bit catches coordinate wrap, which counts as off-screen
  always_comb begin
    bx = (state_q == ERASE) ? prev_x_q : new_x_q;
    by = (state_q == ERASE) ? prev_y_q : new_y_q;
    sx = {1'b0, bx} + {{(COORD_W + 1 - W){1'b0}}, cx};
    sy = {1'b0, by} + {{(COORD_W + 1 - W){1'b0}}, cy};
  end
  assign pixel_x     = busy ? sx[COORD_W-1:0] : '0;
  assign pixel_y     = busy ? sy[COORD_W-1:0] : '0;
  assign pixel_color = (state_q == DRAW);
  assign pixel_we    = busy && !sx[COORD_W] && !sy[COORD_W] &&
                       (sx[COORD_W-1:0] < coord_t'(SCR_W)) && (sy[COORD_W-1:0] < coord_t'(SCR_H));
  assign done        = (state_q == FINISHED);
endmodule

// File: tb/tb_square_drawer.sv
// tb_square_drawer: scoreboard bench for square_drawer erase/draw scan, clipping, handshake and reset
module tb_square_drawer;
  import square_pkg::*;
  logic clk = 0, reset = 1, start = 0;
  coord_t x_loc = '0, y_loc = '0;
  coord_t pixel_x, pixel_y;
  logic pixel_color, pixel_we, busy, done;
  int checks = 0, errors = 0;
  int we_cnt = 0, er_cnt = 0, exp_we = 0;
  logic [22:0] q[$];
  bit m_have = 0;
  int m_px = 0, m_py = 0;

  square_drawer dut (
    .clk(clk), .reset(reset), .start(start), .x_loc(x_loc), .y_loc(y_loc),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_color(pixel_color),
    .pixel_we(pixel_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && pixel_we) begin
      logic [22:0] e;
      we_cnt++;
      if (!pixel_color) er_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected got x=%0d y=%0d c=%0d, required no write", pixel_x, pixel_y, pixel_color);
      end else begin
        e = q.pop_front();
        if ({pixel_x, pixel_y, pixel_color} !== e) begin
          errors++;
          $display("FAIL pix got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                   pixel_x, pixel_y, pixel_color, e[22:12], e[11:1], e[0]);
        end
      end
    end
  end

  always @(negedge clk)
    if (pixel_we) assert (pixel_x < 640 && pixel_y < 480);

  task automatic push_sq(input int x, input int y, input bit c);
    for (int j = 0; j < SQ_SIZE; j++)
      for (int i = 0; i < SQ_SIZE; i++)
        if (x + i < SCREEN_W && y + j < SCREEN_H) begin
          q.push_back({coord_t'(x + i), coord_t'(y + j), c});
          exp_we++;
        end
  endtask

  task automatic run_square(input int x, input int y, input bit tog, input int exp_edges, input string name);
    int n = 0;
    bit hit = 0;
    exp_we = 0; we_cnt = 0; er_cnt = 0;
    if (m_have) push_sq(m_px, m_py, 1'b0);
    push_sq(x, y, 1'b1);
    @(posedge clk); #2;
    start = 1; x_loc = coord_t'(x); y_loc = coord_t'(y);
    for (int k = 0; k < 3000 && !hit; k++) begin
      @(posedge clk);
      n++;
      if (tog && n == 10) begin
        #2 x_loc = ~x_loc; y_loc = ~y_loc;
      end
      @(negedge clk);
      hit = done;
    end
    checks++;
    if (n !== exp_edges) begin
      errors++;
      $display("FAIL %s_done_edge got %0d, required %0d", name, n, exp_edges);
    end
    checks++;
    if (we_cnt !== exp_we || q.size() != 0) begin
      errors++;
      $display("FAIL %s_we_count got %0d (left %0d), required %0d", name, we_cnt, q.size(), exp_we);
    end
    m_have = 1; m_px = x; m_py = y;
  endtask

  task automatic drop_start(input string name);
    @(posedge clk); #2 start = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL %s_idle got done=%0b busy=%0b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #2 reset = 1; start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pixel_x, pixel_y, pixel_color, pixel_we, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got x=%0d y=%0d c=%0b we=%0b busy=%0b done=%0b, required all 0",
               pixel_x, pixel_y, pixel_color, pixel_we, busy, done);
    end
    q.delete(); m_have = 0;
    @(posedge clk); #2 reset = 0;
  endtask

  task automatic test_first_and_redraw;
    run_square(100, 50, 0, 401, "first");
    checks++;
    if (er_cnt !== 0) begin errors++; $display("FAIL first_erase got %0d, required 0", er_cnt); end
    drop_start("first");
    run_square(300, 200, 0, 801, "redraw");
    checks++;
    if (er_cnt !== 400) begin errors++; $display("FAIL redraw_erase got %0d, required 400", er_cnt); end
    drop_start("redraw");
  endtask

  task automatic test_handshake;
    int snap;
    run_square(50, 60, 1, 801, "hold");
    snap = we_cnt;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (done !== 1 || busy !== 0) begin
        errors++;
        $display("FAIL hold_done got done=%0b busy=%0b, required 1 0", done, busy);
      end
    end
    checks++;
    if (we_cnt !== snap) begin errors++; $display("FAIL hold_rescan got %0d, required %0d", we_cnt, snap); end
    drop_start("hold");
  endtask

  task automatic test_reset_mid;
    exp_we = 0;
    push_sq(m_px, m_py, 1'b0);
    push_sq(10, 20, 1'b1);
    @(posedge clk); #2 start = 1; x_loc = 10; y_loc = 20;
    repeat (400 + 150) @(posedge clk);
    #2 reset = 1; start = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (pixel_we !== 0 || done !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL abort got we=%0b done=%0b busy=%0b, required 0 0 0", pixel_we, done, busy);
    end
    q.delete(); m_have = 0;
    @(posedge clk); #2 reset = 0;
    run_square(400, 300, 0, 401, "after_abort");
    checks++;
    if (er_cnt !== 0) begin errors++; $display("FAIL after_abort_erase got %0d, required 0", er_cnt); end
    drop_start("after_abort");
  endtask

  task automatic test_clip;
    test_reset();
    run_square(630, 470, 0, 401, "clip");
    checks++;
    if (we_cnt !== 100) begin errors++; $display("FAIL clip_count got %0d, required 100", we_cnt); end
    drop_start("clip");
    run_square(2040, 100, 0, 801, "wrap");
    checks++;
    if (er_cnt !== 100 || we_cnt !== 100) begin
      errors++;
      $display("FAIL wrap_count got erase=%0d total=%0d, required 100 100", er_cnt, we_cnt);
    end
    drop_start("wrap");
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      run_square(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 0, 801, "rand");
      drop_start("rand");
    end
  endtask

  initial begin
    test_reset();
    test_first_and_redraw();
    test_handshake();
    test_reset_mid();
    test_clip();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
